// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V "mini" pipeline front end.
package riscv_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

    // Instruction field positions consumed by the Control decoder
    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_MSB = 6;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_MSB = 14;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned FUNCT7_MSB = 31;

    // RUN: nothing outstanding, WAIT: response will be kept, KILL: response will be dropped
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_KILL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction/PC holding register behind the IF/ID register.
module fetch_skid_buf
#(
    parameter int unsigned W = 32
)
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_load,
    input  logic         i_drain,
    input  logic [W-1:0] i_instr,
    input  logic [W-1:0] i_pc,
    output logic         o_valid,
    output logic [W-1:0] o_instr,
    output logic [W-1:0] o_pc
);
    import riscv_pkg::*;

    logic         r_valid;
    logic [W-1:0] r_instr;
    logic [W-1:0] r_pc;

    // Flush beats load; load while draining keeps the entry occupied with the new word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, IF/ID register.
module fetch_unit
#(
    parameter int unsigned        XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]    RESET_PC = riscv_pkg::RESET_PC_DEFAULT
)
(
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7
);
    import riscv_pkg::*;

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_instr;
    logic [XLEN-1:0] r_if_pc;

    logic            w_buf_valid;
    logic [XLEN-1:0] w_buf_instr;
    logic [XLEN-1:0] w_buf_pc;

    logic            w_consume;
    logic            w_resp_keep;
    logic            w_resp_to_buf;
    logic            w_buf_drain;
    logic            w_slot_free;
    logic            w_req_raw;
    logic            w_req_valid;
    logic            w_accept;

    assign w_consume   = r_if_valid & ~stall;
    assign w_resp_keep = (r_state == ST_WAIT) & imem_resp_valid & ~redirect_valid;
    assign w_buf_drain = w_consume & w_buf_valid;
    // A kept response goes to the buffer when IF/ID is held, or when IF/ID is being refilled from the buffer
    assign w_resp_to_buf = w_resp_keep & ((r_if_valid & ~w_consume) | w_buf_drain);
    assign w_slot_free   = ~w_buf_valid & ~w_resp_to_buf;

    // Next-state and request-valid decode
    always_comb begin
        w_state_nxt = r_state;
        w_req_raw   = 1'b0;
        case (r_state)
            ST_RUN:  w_req_raw = ~redirect_valid & w_slot_free;
            ST_WAIT: w_req_raw = ~redirect_valid & imem_resp_valid & w_slot_free;
            default: w_req_raw = 1'b0;
        endcase
        w_req_valid = w_req_raw & reset;
        w_accept    = w_req_valid & imem_req_ready;
        case (r_state)
            ST_RUN: begin
                if (w_accept) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_resp_valid)     w_state_nxt = w_accept ? ST_WAIT : ST_RUN;
                else if (redirect_valid) w_state_nxt = ST_KILL;
            end
            ST_KILL: begin
                if (imem_resp_valid) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // PC, outstanding-request address and IF/ID register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else begin
            if (redirect_valid) r_pc <= redirect_pc;
            else if (w_accept)  r_pc <= r_pc + XLEN'(4);

            if (w_accept) r_req_pc <= r_pc;

            if (redirect_valid) begin
                r_if_valid <= 1'b0;
            end else if (w_buf_drain) begin
                r_if_valid <= 1'b1;
                r_if_instr <= w_buf_instr;
                r_if_pc    <= w_buf_pc;
            end else if (w_resp_keep & (~r_if_valid | w_consume)) begin
                r_if_valid <= 1'b1;
                r_if_instr <= imem_resp_data;
                r_if_pc    <= r_req_pc;
            end else if (w_consume) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    fetch_skid_buf #(.W(XLEN)) u_skid (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_flush (redirect_valid),
        .i_load  (w_resp_to_buf),
        .i_drain (w_buf_drain),
        .i_instr (imem_resp_data),
        .i_pc    (r_req_pc),
        .o_valid (w_buf_valid),
        .o_instr (w_buf_instr),
        .o_pc    (w_buf_pc)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign if_id_valid    = r_if_valid;
    assign if_id_instr    = r_if_instr;
    assign if_id_pc       = r_if_pc;
    assign opcode         = r_if_instr[OPCODE_MSB:OPCODE_LSB];
    assign funct3         = r_if_instr[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7         = r_if_instr[FUNCT7_MSB:FUNCT7_LSB];

endmodule
